// File: rtl/mmc1_pkg.sv
// Shared MMC1 definitions: register select codes, serial-load constants and bus payload types.
package mmc1_pkg;

    localparam int unsigned SHIFT_LEN = 5;
    localparam int unsigned SEL_W     = 2;
    localparam int unsigned CNT_W     = 3;

    localparam logic [SEL_W-1:0]     REG_CTRL      = 2'd0;
    localparam logic [SEL_W-1:0]     REG_CHR0      = 2'd1;
    localparam logic [SEL_W-1:0]     REG_CHR1      = 2'd2;
    localparam logic [SEL_W-1:0]     REG_PRG       = 2'd3;
    localparam logic [SHIFT_LEN-1:0] CTRL_RESET_OR = 5'b01100;

    typedef struct packed {
        logic [SEL_W-1:0]     sel;
        logic [SHIFT_LEN-1:0] data;
    } mmc1_wr_t;

    // One synchronized sample of the cartridge bus
    typedef struct packed {
        logic romsel_n;
        logic rw_n;
        logic a14;
        logic a13;
        logic d7;
        logic d0;
    } mmc1_bus_t;

    typedef enum logic {
        M2_LOW  = 1'b0,
        M2_HIGH = 1'b1
    } m2_state_t;

endpackage

// File: rtl/mmc1_bus_sync.sv
// Parameterized flop chain: synchronizes asynchronous strobes, or delays bus bits by the same depth.
module mmc1_bus_sync #(
    parameter int unsigned STAGES = 2,
    parameter int unsigned WIDTH  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [STAGES-1:0][WIDTH-1:0] chain;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/mmc1_serial_loader.sv
// MMC1 CPU-side front end: detects M2 cycle ends on SYS_CLK, runs the 5-write serial load
// and drops the second of back-to-back mapper writes.
module mmc1_serial_loader
    import mmc1_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned MIN_RATIO   = 4
) (
    input  logic             SYS_CLK,
    input  logic             SYS_RST,
    input  logic             CPU_M2,
    input  logic             nCPU_ROMSEL,
    input  logic             nCPU_RW,
    input  logic             CPU_A14,
    input  logic             CPU_A13,
    input  logic             CPU_D7,
    input  logic             CPU_D0,
    output logic             REG_WE,
    output logic [SEL_W-1:0] REG_SEL,
    output logic [4:0]       REG_DATA,
    output logic             CTRL_RESET,
    output logic             WRITE_IGNORED,
    output logic [CNT_W-1:0] SHIFT_COUNT
);

    localparam int unsigned SHREG_W = SHIFT_LEN - 1;
    localparam int unsigned PH_W    = $clog2(MIN_RATIO + 1);

    logic [2:0] strobe_s;
    logic [3:0] data_s;
    logic       m2_s;
    mmc1_bus_t  bus_s;

    mmc1_bus_sync #(.STAGES(SYNC_STAGES), .WIDTH(3)) u_strobe_sync (
        .clk (SYS_CLK),
        .rst (SYS_RST),
        .d   ({CPU_M2, nCPU_ROMSEL, nCPU_RW}),
        .q   (strobe_s)
    );

    mmc1_bus_sync #(.STAGES(SYNC_STAGES), .WIDTH(4)) u_data_align (
        .clk (SYS_CLK),
        .rst (SYS_RST),
        .d   ({CPU_A14, CPU_A13, CPU_D7, CPU_D0}),
        .q   (data_s)
    );

    assign m2_s  = strobe_s[2];
    assign bus_s = '{romsel_n: strobe_s[1], rw_n: strobe_s[0],
                     a14: data_s[3], a13: data_s[2], d7: data_s[1], d0: data_s[0]};

    m2_state_t          state, state_n;
    mmc1_bus_t          snap, snap_n;
    logic               prev_write, prev_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [SHREG_W-1:0] shreg, shreg_n;
    mmc1_wr_t           wr_q, wr_n;
    logic               we_n, crst_n, ign_n;
    logic               map_wr_c;

    assign map_wr_c = !snap.romsel_n && !snap.rw_n;

    always_ff @(posedge SYS_CLK or posedge SYS_RST) begin
        if (SYS_RST) begin
            state         <= M2_LOW;
            snap          <= '0;
            prev_write    <= 1'b0;
            cnt           <= '0;
            shreg         <= '0;
            wr_q          <= '0;
            REG_WE        <= 1'b0;
            CTRL_RESET    <= 1'b0;
            WRITE_IGNORED <= 1'b0;
        end else begin
            state         <= state_n;
            snap          <= snap_n;
            prev_write    <= prev_n;
            cnt           <= cnt_n;
            shreg         <= shreg_n;
            wr_q          <= wr_n;
            REG_WE        <= we_n;
            CTRL_RESET    <= crst_n;
            WRITE_IGNORED <= ign_n;
        end
    end

    // Snapshot while M2 is high; evaluate the last high sample once on the falling edge
    always_comb begin
        state_n = state;
        snap_n  = snap;
        prev_n  = prev_write;
        cnt_n   = cnt;
        shreg_n = shreg;
        wr_n    = wr_q;
        we_n    = 1'b0;
        crst_n  = 1'b0;
        ign_n   = 1'b0;

        if (m2_s) begin
            snap_n = bus_s;
        end

        case (state)
            M2_LOW: begin
                if (m2_s) begin
                    state_n = M2_HIGH;
                end
            end
            M2_HIGH: begin
                if (!m2_s) begin
                    state_n = M2_LOW;
                    prev_n  = map_wr_c;
                    if (map_wr_c) begin
                        if (prev_write) begin
                            ign_n = 1'b1;
                        end else if (snap.d7) begin
                            crst_n  = 1'b1;
                            cnt_n   = '0;
                            shreg_n = '0;
                        end else if (cnt == CNT_W'(SHIFT_LEN - 1)) begin
                            we_n      = 1'b1;
                            wr_n.sel  = {snap.a14, snap.a13};
                            wr_n.data = {snap.d0, shreg};
                            cnt_n     = '0;
                            shreg_n   = '0;
                        end else begin
                            shreg_n = {snap.d0, shreg[SHREG_W-1:1]};
                            cnt_n   = cnt + CNT_W'(1);
                        end
                    end
                end
            end
            default: state_n = M2_LOW;
        endcase
    end

    assign REG_SEL     = wr_q.sel;
    assign REG_DATA    = wr_q.data;
    assign SHIFT_COUNT = cnt;

    // Phase-length monitor for the oversampling ratio; it drives nothing but the assertion
    logic [PH_W-1:0] phase_len;
    logic            phase_seen;

    always_ff @(posedge SYS_CLK or posedge SYS_RST) begin
        if (SYS_RST) begin
            phase_len  <= '0;
            phase_seen <= 1'b0;
        end else if (m2_s != (state == M2_HIGH)) begin
            assert (!phase_seen || phase_len >= PH_W'(MIN_RATIO));
            phase_len  <= PH_W'(1);
            phase_seen <= 1'b1;
        end else if (phase_len < PH_W'(MIN_RATIO)) begin
            phase_len <= phase_len + PH_W'(1);
        end
    end

endmodule

// File: tb/tb_mmc1_serial_loader.sv
// Scoreboard bench for mmc1_serial_loader: directed protocol cases plus randomized bus traffic.
`timescale 1ns/1ps
module tb_mmc1_serial_loader;

    localparam realtime SYS_HALF = 23.28;
    localparam realtime M2_HALF  = 279.33;

    logic       SYS_CLK = 1'b0;
    logic       SYS_RST = 1'b1;
    logic       CPU_M2 = 1'b0, nCPU_ROMSEL = 1'b1, nCPU_RW = 1'b1;
    logic       CPU_A14 = 1'b0, CPU_A13 = 1'b0, CPU_D7 = 1'b0, CPU_D0 = 1'b0;
    logic       REG_WE, CTRL_RESET, WRITE_IGNORED;
    logic [1:0] REG_SEL;
    logic [4:0] REG_DATA;
    logic [2:0] SHIFT_COUNT;

    mmc1_serial_loader #(.SYNC_STAGES(2), .MIN_RATIO(4)) dut (
        .SYS_CLK       (SYS_CLK),
        .SYS_RST       (SYS_RST),
        .CPU_M2        (CPU_M2),
        .nCPU_ROMSEL   (nCPU_ROMSEL),
        .nCPU_RW       (nCPU_RW),
        .CPU_A14       (CPU_A14),
        .CPU_A13       (CPU_A13),
        .CPU_D7        (CPU_D7),
        .CPU_D0        (CPU_D0),
        .REG_WE        (REG_WE),
        .REG_SEL       (REG_SEL),
        .REG_DATA      (REG_DATA),
        .CTRL_RESET    (CTRL_RESET),
        .WRITE_IGNORED (WRITE_IGNORED),
        .SHIFT_COUNT   (SHIFT_COUNT)
    );

    always #(SYS_HALF) SYS_CLK = ~SYS_CLK;

    typedef struct {
        logic [2:0] pulses;
        logic [1:0] sel;
        logic [4:0] data;
    } ev_t;

    ev_t exp_q[$];
    bit  model_bits[$];
    bit  model_prev;
    int  total = 0;
    int  bad = 0;
    int  we_exp = 0;
    int  we_seen = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a mapper write is accepted unless the previous cycle was also one
    task automatic model_cycle(input bit romsel_n, input bit rw_n, input bit [1:0] sel,
                               input bit d7, input bit d0);
        bit  wr;
        ev_t e;
        wr = !romsel_n && !rw_n;
        if (wr) begin
            e.sel = 2'd0;
            e.data = 5'd0;
            if (model_prev) begin
                e.pulses = 3'b001;
                exp_q.push_back(e);
            end else if (d7) begin
                e.pulses = 3'b010;
                exp_q.push_back(e);
                model_bits.delete();
            end else begin
                model_bits.push_back(d0);
                if (model_bits.size() == 5) begin
                    e.pulses = 3'b100;
                    e.sel = sel;
                    for (int i = 0; i < 5; i++) e.data[i] = model_bits[i];
                    exp_q.push_back(e);
                    model_bits.delete();
                    we_exp++;
                end
            end
        end
        model_prev = wr;
    endtask

    task automatic monitor();
        ev_t e;
        forever begin
            @(negedge SYS_CLK);
            if (!SYS_RST && (REG_WE || CTRL_RESET || WRITE_IGNORED)) begin
                if (REG_WE) we_seen++;
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", int'({REG_WE, CTRL_RESET, WRITE_IGNORED}), 0);
                end else begin
                    e = exp_q.pop_front();
                    check("pulse_kind", int'({REG_WE, CTRL_RESET, WRITE_IGNORED}), int'(e.pulses));
                    if (REG_WE) begin
                        check("reg_sel", int'(REG_SEL), int'(e.sel));
                        check("reg_data", int'(REG_DATA), int'(e.data));
                    end
                end
            end
        end
    endtask

    // One CPU cycle: count check, address phase, M2 high, fall, bus released
    task automatic bus_cycle(input bit romsel_n, input bit rw_n, input bit [1:0] sel,
                             input bit d7, input bit d0, input int jitter_ns);
        @(negedge SYS_CLK);
        check("shift_count", int'(SHIFT_COUNT), model_bits.size());
        #(jitter_ns * 1.0ns);
        nCPU_ROMSEL = romsel_n;
        nCPU_RW     = rw_n;
        {CPU_A14, CPU_A13} = sel;
        CPU_D7 = d7;
        CPU_D0 = d0;
        #30;
        CPU_M2 = 1'b1;
        #(M2_HALF);
        CPU_M2 = 1'b0;
        model_cycle(romsel_n, rw_n, sel, d7, d0);
        #10;
        nCPU_ROMSEL = 1'b1;
        nCPU_RW     = 1'b1;
        #200;
    endtask

    task automatic wr(input bit [1:0] sel, input bit d0);
        bus_cycle(1'b0, 1'b0, sel, 1'b0, d0, 0);
    endtask

    task automatic rd();
        bus_cycle(1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 0);
    endtask

    task automatic check_all_zero(input string name);
        check(name, int'({REG_WE, REG_SEL, REG_DATA, CTRL_RESET, WRITE_IGNORED, SHIFT_COUNT}), 0);
    endtask

    initial begin
        #(20ms);
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        bit d7;
        model_prev = 1'b0;
        #1;
        check_all_zero("reset_outputs");
        #100;
        SYS_RST = 1'b0;
        fork
            monitor();
        join_none
        #100;

        // Five writes to $E000 with reads between
        wr(2'd3, 1'b1); rd(); wr(2'd3, 1'b0); rd(); wr(2'd3, 1'b1); rd();
        wr(2'd3, 1'b1); rd(); wr(2'd3, 1'b0); rd();
        check("t1_data", int'(REG_DATA), 5'b01101);

        // Two writes, then a D7 reset write, then a full $A000 load
        wr(2'd0, 1'b1); rd(); wr(2'd0, 1'b1); rd();
        bus_cycle(1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 0); rd();
        wr(2'd1, 1'b0); rd(); wr(2'd1, 1'b1); rd(); wr(2'd1, 1'b0); rd();
        wr(2'd1, 1'b0); rd(); wr(2'd1, 1'b1); rd();
        check("t2_sel", int'(REG_SEL), 1);

        // RMW: back-to-back writes drop the second; first bit survives
        wr(2'd0, 1'b1); wr(2'd0, 1'b0); rd();
        wr(2'd0, 1'b0); rd(); wr(2'd0, 1'b0); rd(); wr(2'd0, 1'b0); rd(); wr(2'd0, 1'b0); rd();
        check("t3_data", int'(REG_DATA), 5'b00001);

        // Select from the 5th write; $6000 write does not count
        wr(2'd0, 1'b0); rd(); wr(2'd0, 1'b1); rd(); wr(2'd0, 1'b1); rd();
        bus_cycle(1'b1, 1'b0, 2'd3, 1'b0, 1'b1, 0);
        wr(2'd2, 1'b1); rd(); wr(2'd2, 1'b1); rd();
        check("t4_sel", int'(REG_SEL), 2);

        // Async reset mid-sequence
        wr(2'd0, 1'b1); rd(); wr(2'd0, 1'b0); rd(); wr(2'd0, 1'b1);
        #20;
        SYS_RST = 1'b1;
        #1;
        check_all_zero("t5_reset_outputs");
        model_bits.delete();
        model_prev = 1'b0;
        #60;
        SYS_RST = 1'b0;
        #100;
        for (int i = 0; i < 5; i++) begin
            wr(2'd0, 1'b1); rd();
        end
        check("t5_data", int'(REG_DATA), 5'b11111);

        // Randomized traffic with random phase
        for (int s = 0; s < 1000; s++) begin
            for (int c = 0; c < 3; c++) begin
                r  = int'($urandom_range(0, 99));
                d7 = ($urandom_range(0, 99) < 4);
                if (r < 55)      bus_cycle(1'b0, 1'b0, 2'($urandom_range(0, 3)), d7, 1'($urandom_range(0, 1)), int'($urandom_range(0, 46)));
                else if (r < 70) bus_cycle(1'b0, 1'b1, 2'($urandom_range(0, 3)), d7, 1'($urandom_range(0, 1)), int'($urandom_range(0, 46)));
                else if (r < 80) bus_cycle(1'b1, 1'b0, 2'($urandom_range(0, 3)), d7, 1'($urandom_range(0, 1)), int'($urandom_range(0, 46)));
                else             bus_cycle(1'b1, 1'b1, 2'($urandom_range(0, 3)), d7, 1'($urandom_range(0, 1)), int'($urandom_range(0, 46)));
            end
        end

        repeat (20) @(negedge SYS_CLK);
        check("final_shift_count", int'(SHIFT_COUNT), model_bits.size());
        check("pending_events", exp_q.size(), 0);
        check("reg_we_total", we_seen, we_exp);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
